i2c_frame_slave: RTL and testbench

Open-drain I2C target that receives fixed-length frames from the design's I2C master, which sends 13 bytes MSB-chunk-first to address 7'h07. It oversamples SCL and SDA on the system clock, detects START and STOP, matches the address and ACKs each byte. It assembles the bytes into a parallel frame register and publishes the frame to the fabric as a single-cycle strobe once a complete frame ends in STOP.

---
 rtl/i2c_frame_slave.sv | 268 ++++++++++++++++++++++++++
 tb/tb_i2c_frame_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_frame_slave.sv
// Open-drain I2C write target: oversamples SCL/SDA, ACKs its address and assembles FRAME_BYTES-byte frames.
// Define I2C_SLAVE_READ_EN to compile in read-back of data_out (R/W=1 transfers).
module i2c_frame_slave #(
   parameter logic [6:0] ADDR        = 7'b0000111,
   parameter int         FRAME_BYTES = 13
) (
   input  logic                     clk,
   input  logic                     rst,
   inout  wire                      i2c_scl,
   inout  wire                      i2c_sda,
   output logic [8*FRAME_BYTES-1:0] data_out,
   output logic                     frame_valid,
   output logic                     busy,
   output logic [3:0]               byte_count,
   output logic                     short_err,
   output logic                     overrun
);

   localparam int         DW = 8 * FRAME_BYTES;
   localparam logic [3:0] FB = 4'(FRAME_BYTES);

`ifdef I2C_SLAVE_READ_EN
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_IGNORE, S_TX_BYTE, S_TX_ACK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_IGNORE
   } state_t;
`endif

   logic scl_meta_reg, scl_sync_reg, scl_reg;
   logic sda_meta_reg, sda_sync_reg, sda_reg;

   state_t          state_reg, state_next;
   logic [3:0]      bit_cnt_reg, bit_cnt_next;
   logic [7:0]      shift_reg, shift_next;
   logic            sda_oe_reg, sda_oe_next;
   logic [DW-1:0]   staging_reg, staging_next;
   logic [DW-1:0]   data_out_reg, data_out_next;
   logic            frame_valid_reg, frame_valid_next;
   logic            busy_reg, busy_next;
   logic [3:0]      byte_count_reg, byte_count_next;
   logic            short_err_reg, short_err_next;
   logic            overrun_reg, overrun_next;
`ifdef I2C_SLAVE_READ_EN
   logic            rw_reg, rw_next;
   logic [3:0]      tx_idx_reg, tx_idx_next;
   logic [7:0]      tx_shift_reg, tx_shift_next;
   logic            tx_ack_reg, tx_ack_next;
   logic [7:0]      tx_byte;
`endif

   logic scl_rise, scl_fall, start_det, stop_det;

   // Idle bus is high, so the chains reset to 1 to avoid phantom edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_meta_reg <= 1'b1;
         scl_sync_reg <= 1'b1;
         scl_reg      <= 1'b1;
         sda_meta_reg <= 1'b1;
         sda_sync_reg <= 1'b1;
         sda_reg      <= 1'b1;
      end else begin
         scl_meta_reg <= i2c_scl;
         scl_sync_reg <= scl_meta_reg;
         scl_reg      <= scl_sync_reg;
         sda_meta_reg <= i2c_sda;
         sda_sync_reg <= sda_meta_reg;
         sda_reg      <= sda_sync_reg;
      end
   end

   assign scl_rise  = scl_sync_reg & ~scl_reg;
   assign scl_fall  = ~scl_sync_reg & scl_reg;
   assign start_det = scl_sync_reg & scl_reg & sda_reg & ~sda_sync_reg;
   assign stop_det  = scl_sync_reg & scl_reg & ~sda_reg & sda_sync_reg;

`ifdef I2C_SLAVE_READ_EN
   always_comb begin
      tx_byte = 8'hFF;
      if (tx_idx_reg < FB)
         tx_byte = data_out_reg[DW-1-8*int'(tx_idx_reg) -: 8];
   end
`endif

   always_comb begin
      state_next       = state_reg;
      bit_cnt_next     = bit_cnt_reg;
      shift_next       = shift_reg;
      sda_oe_next      = sda_oe_reg;
      staging_next     = staging_reg;
      data_out_next    = data_out_reg;
      frame_valid_next = 1'b0;
      busy_next        = busy_reg;
      byte_count_next  = byte_count_reg;
      short_err_next   = 1'b0;
      overrun_next     = overrun_reg;
`ifdef I2C_SLAVE_READ_EN
      rw_next          = rw_reg;
      tx_idx_next      = tx_idx_reg;
      tx_shift_next    = tx_shift_reg;
      tx_ack_next      = tx_ack_reg;
`endif
      // Bus conditions win over any SCL edge seen in the same cycle.
      if (start_det || stop_det) begin
         sda_oe_next     = 1'b0;
         bit_cnt_next    = 4'd0;
         busy_next       = 1'b0;
         byte_count_next = 4'd0;
         if (byte_count_reg == FB) begin
            if (stop_det) begin
               data_out_next    = staging_reg;
               frame_valid_next = 1'b1;
            end
         end else if (byte_count_reg != 4'd0) begin
            short_err_next = 1'b1;
         end
         state_next = start_det ? S_ADDR : S_IDLE;
      end else begin
         case (state_reg)
            S_ADDR: begin
               if (scl_rise && bit_cnt_reg < 4'd8) begin
                  shift_next   = {shift_reg[6:0], sda_sync_reg};
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                  bit_cnt_next = 4'd0;
                  state_next   = S_IGNORE;
                  if (shift_reg[7:1] == ADDR && !shift_reg[0]) begin
                     sda_oe_next = 1'b1;
                     busy_next   = 1'b1;
                     state_next  = S_ADDR_ACK;
`ifdef I2C_SLAVE_READ_EN
                     rw_next     = 1'b0;
                  end else if (shift_reg[7:1] == ADDR) begin
                     sda_oe_next = 1'b1;
                     busy_next   = 1'b1;
                     state_next  = S_ADDR_ACK;
                     rw_next     = 1'b1;
                     tx_idx_next = 4'd0;
`endif
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  sda_oe_next = 1'b0;
                  state_next  = S_RX_BYTE;
`ifdef I2C_SLAVE_READ_EN
                  if (rw_reg) begin
                     tx_shift_next = tx_byte;
                     sda_oe_next   = ~tx_byte[7];
                     tx_idx_next   = (tx_idx_reg == FB) ? tx_idx_reg : tx_idx_reg + 4'd1;
                     state_next    = S_TX_BYTE;
                  end
`endif
               end
            end
            S_RX_BYTE: begin
               if (scl_rise && bit_cnt_reg < 4'd8) begin
                  shift_next   = {shift_reg[6:0], sda_sync_reg};
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                  bit_cnt_next = 4'd0;
                  if (byte_count_reg == FB) begin
                     overrun_next = 1'b1;
                     state_next   = S_IGNORE;
                  end else begin
                     staging_next[DW-1-8*int'(byte_count_reg) -: 8] = shift_reg;
                     byte_count_next = byte_count_reg + 4'd1;
                     sda_oe_next     = 1'b1;
                     state_next      = S_RX_ACK;
                  end
               end
            end
            S_RX_ACK: begin
               if (scl_fall) begin
                  sda_oe_next = 1'b0;
                  state_next  = S_RX_BYTE;
               end
            end
`ifdef I2C_SLAVE_READ_EN
            S_TX_BYTE: begin
               if (scl_rise && bit_cnt_reg < 4'd8) begin
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_reg == 4'd8) begin
                     bit_cnt_next = 4'd0;
                     sda_oe_next  = 1'b0;
                     state_next   = S_TX_ACK;
                  end else begin
                     tx_shift_next = {tx_shift_reg[6:0], 1'b1};
                     sda_oe_next   = ~tx_shift_reg[6];
                  end
               end
            end
            S_TX_ACK: begin
               if (scl_rise) begin
                  tx_ack_next = ~sda_sync_reg;
               end else if (scl_fall) begin
                  if (tx_ack_reg) begin
                     tx_shift_next = tx_byte;
                     sda_oe_next   = ~tx_byte[7];
                     tx_idx_next   = (tx_idx_reg == FB) ? tx_idx_reg : tx_idx_reg + 4'd1;
                     state_next    = S_TX_BYTE;
                  end else begin
                     sda_oe_next = 1'b0;
                     busy_next   = 1'b0;
                     state_next  = S_IGNORE;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= S_IDLE;
         bit_cnt_reg     <= 4'd0;
         shift_reg       <= 8'd0;
         sda_oe_reg      <= 1'b0;
         staging_reg     <= '0;
         data_out_reg    <= '0;
         frame_valid_reg <= 1'b0;
         busy_reg        <= 1'b0;
         byte_count_reg  <= 4'd0;
         short_err_reg   <= 1'b0;
         overrun_reg     <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
         rw_reg          <= 1'b0;
         tx_idx_reg      <= 4'd0;
         tx_shift_reg    <= 8'hFF;
         tx_ack_reg      <= 1'b0;
`endif
      end else begin
         state_reg       <= state_next;
         bit_cnt_reg     <= bit_cnt_next;
         shift_reg       <= shift_next;
         sda_oe_reg      <= sda_oe_next;
         staging_reg     <= staging_next;
         data_out_reg    <= data_out_next;
         frame_valid_reg <= frame_valid_next;
         busy_reg        <= busy_next;
         byte_count_reg  <= byte_count_next;
         short_err_reg   <= short_err_next;
         overrun_reg     <= overrun_next;
`ifdef I2C_SLAVE_READ_EN
         rw_reg          <= rw_next;
         tx_idx_reg      <= tx_idx_next;
         tx_shift_reg    <= tx_shift_next;
         tx_ack_reg      <= tx_ack_next;
`endif
      end
   end

   assign i2c_sda     = sda_oe_reg ? 1'b0 : 1'bz;
   assign data_out    = data_out_reg;
   assign frame_valid = frame_valid_reg;
   assign busy        = busy_reg;
   assign byte_count  = byte_count_reg;
   assign short_err   = short_err_reg;
   assign overrun     = overrun_reg;

endmodule

// File: tb/tb_i2c_frame_slave.sv
// Directed bench for i2c_frame_slave: bit-banged I2C master with open-drain SDA and pull-up.
module tb_i2c_frame_slave;

   localparam int Q = 40;
   localparam int H = 80;

   logic clk = 1'b0;
   logic rst;
   logic m_scl;
   logic m_sda_low;
   wire  i2c_scl;
   wire  i2c_sda;

   logic [103:0] data_out;
   logic         frame_valid, busy, short_err, overrun;
   logic [3:0]   byte_count;

   int n_checks = 0;
   int n_fail   = 0;

   int fv_cnt = 0, se_cnt = 0, busy_cyc = 0, drv_cyc = 0;

   assign i2c_scl = m_scl;
   assign i2c_sda = m_sda_low ? 1'b0 : 1'bz;
   pullup (i2c_sda);

   always #5 clk = ~clk;

   i2c_frame_slave dut (
      .clk        (clk),
      .rst        (rst),
      .i2c_scl    (i2c_scl),
      .i2c_sda    (i2c_sda),
      .data_out   (data_out),
      .frame_valid(frame_valid),
      .busy       (busy),
      .byte_count (byte_count),
      .short_err  (short_err),
      .overrun    (overrun)
   );

   always @(negedge clk) begin
      if (frame_valid === 1'b1) fv_cnt++;
      if (short_err === 1'b1) se_cnt++;
      if (busy === 1'b1) busy_cyc++;
      if (!m_sda_low && i2c_sda === 1'b0) drv_cyc++;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic i2c_start();
      m_sda_low = 1'b0; m_scl = 1'b1; #(H);
      m_sda_low = 1'b1; #(H);
      m_scl = 1'b0; #(Q);
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1; #(Q);
      m_scl = 1'b1; #(H);
      m_sda_low = 1'b0; #(H);
   endtask

   task automatic send_bit(input logic b);
      m_sda_low = ~b; #(Q);
      m_scl = 1'b1; #(H);
      m_scl = 1'b0; #(Q);
   endtask

   task automatic recv_bit(output logic b);
      m_sda_low = 1'b0; #(Q);
      m_scl = 1'b1; #(Q);
      b = i2c_sda; #(Q);
      m_scl = 1'b0; #(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic nb;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(nb);
      ack = ~nb;
      $display("write byte %02h ack=%0b", d, ack);
   endtask

   task automatic recv_byte(input logic ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(~ack);
      $display("read byte %02h ack=%0b", d, ack);
   endtask

   initial begin
      logic         ack;
      logic [7:0]   addr_w, rd;
      logic [103:0] frame1, frame4, frame5;
      int fv0, se0, bz0, dr0, nack;

      addr_w = 8'h0E;
      frame1 = 104'h0102030405060708090A0B0C0D;
      frame4 = 104'h2122232425262728292A2B2C2D;
      frame5 = 104'h6162636465666768696A6B6C6D;

      rst = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0;
      #100;
      check("rst_data_out", data_out, 0);
      check("rst_frame_valid", frame_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_byte_count", byte_count, 0);
      check("rst_short_err", short_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_sda", i2c_sda, 1);
      rst = 1'b0;
      #100;

      // Full 13-byte frame
      fv0 = fv_cnt;
      i2c_start();
      send_byte(addr_w, ack);
      check("f1_addr_ack", ack, 1);
      check("f1_busy", busy, 1);
      nack = 0;
      for (int k = 1; k <= 13; k++) begin
         send_byte(8'(k), ack);
         if (!ack) nack++;
      end
      check("f1_nacks", nack, 0);
      check("f1_byte_count", byte_count, 13);
      i2c_stop();
      check("f1_fv_pulses", fv_cnt - fv0, 1);
      check("f1_byte0", data_out[103:96], 8'h01);
      check("f1_byte12", data_out[7:0], 8'h0D);
      check("f1_frame", data_out, frame1);
      check("f1_busy_after", busy, 0);
      check("f1_byte_count_after", byte_count, 0);

      // Wrong address
      fv0 = fv_cnt; bz0 = busy_cyc; dr0 = drv_cyc;
      i2c_start();
      send_byte(8'h10, ack);
      check("bad_addr_ack", ack, 0);
      send_byte(8'hAA, ack);
      check("bad_data_ack", ack, 0);
      i2c_stop();
      check("bad_busy_cycles", busy_cyc - bz0, 0);
      check("bad_sda_driven", drv_cyc - dr0, 0);
      check("bad_fv", fv_cnt - fv0, 0);
      check("bad_data_out", data_out, frame1);

      // Short frame
      fv0 = fv_cnt; se0 = se_cnt;
      i2c_start();
      send_byte(addr_w, ack);
      nack = 0;
      for (int k = 0; k < 5; k++) begin
         send_byte(8'h51 + 8'(k), ack);
         if (!ack) nack++;
      end
      check("short_nacks", nack, 0);
      check("short_byte_count", byte_count, 5);
      i2c_stop();
      check("short_err_pulses", se_cnt - se0, 1);
      check("short_fv", fv_cnt - fv0, 0);
      check("short_data_out", data_out, frame1);

      // Overrun: 14 bytes
      fv0 = fv_cnt; se0 = se_cnt;
      i2c_start();
      send_byte(addr_w, ack);
      nack = 0;
      for (int k = 0; k < 13; k++) begin
         send_byte(8'h21 + 8'(k), ack);
         if (!ack) nack++;
      end
      check("ovr_nacks13", nack, 0);
      check("ovr_overrun_before", overrun, 0);
      send_byte(8'h2E, ack);
      check("ovr_byte14_ack", ack, 0);
      check("ovr_overrun", overrun, 1);
      check("ovr_busy", busy, 1);
      i2c_stop();
      check("ovr_fv", fv_cnt - fv0, 1);
      check("ovr_short_err", se_cnt - se0, 0);
      check("ovr_byte0", data_out[103:96], 8'h21);
      check("ovr_byte12", data_out[7:0], 8'h2D);
      check("ovr_overrun_sticky", overrun, 1);

      // Reset while the address ACK is being driven
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(addr_w[i]);
      m_sda_low = 1'b0;
      #(Q);
      check("rst_ack_driven", i2c_sda, 0);
      check("rst_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      check("rst_sda_released", i2c_sda, 1);
      #19;
      check("rst2_data_out", data_out, 0);
      check("rst2_overrun", overrun, 0);
      check("rst2_busy", busy, 0);
      check("rst2_byte_count", byte_count, 0);
      check("rst2_frame_valid", frame_valid, 0);
      check("rst2_short_err", short_err, 0);
      m_scl = 1'b1;
      #(H);
      rst = 1'b0;
      #(H);

      fv0 = fv_cnt;
      i2c_start();
      send_byte(addr_w, ack);
      check("f5_addr_ack", ack, 1);
      nack = 0;
      for (int k = 0; k < 13; k++) begin
         send_byte(8'h61 + 8'(k), ack);
         if (!ack) nack++;
      end
      check("f5_nacks", nack, 0);
      i2c_stop();
      check("f5_fv", fv_cnt - fv0, 1);
      check("f5_frame", data_out, frame5);

`ifdef I2C_SLAVE_READ_EN
      i2c_start();
      send_byte(8'h0F, ack);
      check("rd_addr_ack", ack, 1);
      recv_byte(1'b1, rd);
      check("rd_byte0", rd, 8'h61);
      recv_byte(1'b1, rd);
      check("rd_byte1", rd, 8'h62);
      recv_byte(1'b0, rd);
      check("rd_byte2", rd, 8'h63);
      m_sda_low = 1'b0;
      #(Q);
      check("rd_sda_released", i2c_sda, 1);
      check("rd_busy_after_nack", busy, 0);
      i2c_stop();
`endif

      #200;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
